// File: rtl/ibex_multdiv_issue.sv
// Issue/response stage in front of the iterative mult/div unit: registers one
// request, sequences the unit controls and returns the result to writeback.
module ibex_multdiv_issue #(
  parameter bit ResultCache = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        data_ind_timing_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_operator_i,
  input  logic [1:0]  req_signed_mode_i,
  input  logic [31:0] req_op_a_i,
  input  logic [31:0] req_op_b_i,
  input  logic [4:0]  req_rd_i,
  output logic        md_mult_en_o,
  output logic        md_div_en_o,
  output logic        md_mult_sel_o,
  output logic        md_div_sel_o,
  output logic [1:0]  md_operator_o,
  output logic [1:0]  md_signed_mode_o,
  output logic [31:0] md_op_a_o,
  output logic [31:0] md_op_b_o,
  output logic        md_ready_id_o,
  input  logic        md_valid_i,
  input  logic [31:0] md_result_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic [4:0]  rsp_rd_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RESP} state_e;

  state_e      state, state_d;
  logic        accept, hit, engaged_d;
  logic [1:0]  op_d;

  logic        cache_valid;
  logic [1:0]  cache_op, cache_mode;
  logic [31:0] cache_a, cache_b, cache_val;

  assign req_ready_o = ~flush_i & ((state == IDLE) | ((state == RESP) & rsp_ready_i));
  assign accept      = req_valid_i & req_ready_o;

  assign hit = ResultCache & cache_valid & ~data_ind_timing_i &
               (cache_op == req_operator_i) & (cache_mode == req_signed_mode_i) &
               (cache_a == req_op_a_i) & (cache_b == req_op_b_i);

  // Flush outranks completion; DRAIN ignores flush and waits for the unit to finish.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (accept) state_d = hit ? RESP : BUSY;
      BUSY: begin
        if (flush_i)         state_d = md_valid_i ? IDLE : DRAIN;
        else if (md_valid_i) state_d = RESP;
      end
      DRAIN: if (md_valid_i) state_d = IDLE;
      RESP: begin
        if (flush_i)          state_d = IDLE;
        else if (rsp_ready_i) state_d = accept ? (hit ? RESP : BUSY) : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign op_d      = accept ? req_operator_i : md_operator_o;
  assign engaged_d = (state_d == BUSY) | (state_d == DRAIN);

  // Unit controls are registered from the next state and the operator it will run.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      md_mult_en_o     <= 1'b0;
      md_mult_sel_o    <= 1'b0;
      md_div_en_o      <= 1'b0;
      md_div_sel_o     <= 1'b0;
      md_ready_id_o    <= 1'b0;
      rsp_valid_o      <= 1'b0;
      md_operator_o    <= 2'b00;
      md_signed_mode_o <= 2'b00;
      md_op_a_o        <= 32'h0;
      md_op_b_o        <= 32'h0;
      rsp_rd_o         <= 5'h0;
      rsp_result_o     <= 32'h0;
      cache_valid      <= 1'b0;
      cache_op         <= 2'b00;
      cache_mode       <= 2'b00;
      cache_a          <= 32'h0;
      cache_b          <= 32'h0;
      cache_val        <= 32'h0;
    end else begin
      state         <= state_d;
      md_mult_en_o  <= engaged_d & ~op_d[1];
      md_mult_sel_o <= engaged_d & ~op_d[1];
      md_div_en_o   <= engaged_d & op_d[1];
      md_div_sel_o  <= engaged_d & op_d[1];
      md_ready_id_o <= engaged_d;
      rsp_valid_o   <= (state_d == RESP);

      if (accept) begin
        md_operator_o    <= req_operator_i;
        md_signed_mode_o <= req_signed_mode_i;
        md_op_a_o        <= req_op_a_i;
        md_op_b_o        <= req_op_b_i;
        rsp_rd_o         <= req_rd_i;
        if (hit) rsp_result_o <= cache_val;
      end

      // Only an unflushed completion refreshes the result and the cache entry.
      if ((state == BUSY) && md_valid_i && !flush_i) begin
        rsp_result_o <= md_result_i;
        cache_valid  <= 1'b1;
        cache_op     <= md_operator_o;
        cache_mode   <= md_signed_mode_o;
        cache_a      <= md_op_a_o;
        cache_b      <= md_op_b_o;
        cache_val    <= md_result_i;
      end
    end
  end

endmodule
